// File: rtl/vec_store_serializer_if.sv
// Handshake bundle between the vector store serializer, its upstream producer and the data memory.
// Carries the vector request (valid/ready) and the single-lane memory write port (we/ready).
// slave = serializer side, master = producer/memory side.
interface vec_store_serializer_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16
) ();

  // upstream vector store request
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LANE_W-1:0] in_data;
  logic [ADDR_W-1:0]       in_addr;
  logic [LANES-1:0]        in_mask;

  // downstream single-lane memory write port
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LANE_W-1:0]       mem_wdata;
  logic                    mem_ready;

  // request fully drained
  logic                    done;

  modport slave (
    input  in_valid, in_data, in_addr, in_mask, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, done
  );

  modport master (
    output in_valid, in_data, in_addr, in_mask, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, done
  );

endinterface

// File: rtl/vec_store_serializer.sv
// Drains one masked vector to a lane-wide memory as ascending single-lane writes (lane i -> base+i).
// Latency: first write the cycle after capture; K set lanes take K write cycles plus one done cycle.
// Backpressure: in_ready only in IDLE; a write is held stable while mem_ready is low.
module vec_store_serializer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  vec_store_serializer_if.slave bus
);

  localparam int LW = $clog2(LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [LANES*LANE_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES-1:0]        pend_q, pend_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [LANES-1:0]        lane_onehot;
  logic [LANES-1:0]        pend_after;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [LW-1:0] lowest_set(input logic [LANES-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  // Next-state: capture in IDLE, retire one lane per accepted write, single DONE cycle.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    base_d      = base_q;
    pend_d      = pend_q;
    lane_d      = lane_q;
    lane_onehot = '0;
    lane_onehot[lane_q] = 1'b1;
    pend_after  = pend_q & ~lane_onehot;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          base_d  = bus.in_addr;
          pend_d  = bus.in_mask;
          lane_d  = lowest_set(bus.in_mask);
          state_d = (bus.in_mask == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          pend_d = pend_after;
          lane_d = lowest_set(pend_after);
          if (pend_after == '0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      base_q  <= '0;
      pend_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
    end
  end

  // Outputs decode registered state only; address/data are forced to zero outside WRITE.
  // The address add wraps modulo 2^ADDR_W by truncation.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mem_addr  = (state_q == S_WRITE) ? (base_q + ADDR_W'(lane_q)) : '0;
  assign bus.mem_wdata = (state_q == S_WRITE) ? data_q[int'(lane_q) * LANE_W +: LANE_W] : '0;

endmodule

// File: tb/tb_vec_store_serializer.sv
// Directed bench for vec_store_serializer: drives requests, models the memory (with stalls),
// logs accepted writes and checks order, addresses, data and cycle timing against hand values.
module tb_vec_store_serializer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   n_done;

  vec_store_serializer_if #(.LANES(16), .LANE_W(16), .ADDR_W(16)) bus ();

  vec_store_serializer #(.LANES(16), .LANE_W(16), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // accepted-write log
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_edge[$];

  // memory stall control
  logic [15:0] stall_addr;
  int          stall_left;
  int          stall_seen;
  int          stall_bad;
  logic [15:0] stall_dat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: decide mem_ready for the coming edge, log writes it will accept, count done pulses.
  initial begin
    bus.mem_ready = 1'b1;
    stall_left = 0;
    stall_seen = 0;
    stall_bad  = 0;
    stall_addr = '0;
    stall_dat  = '0;
    n_done     = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_we && stall_left > 0 && bus.mem_addr == stall_addr) begin
        if (stall_seen == 0) stall_dat = bus.mem_wdata;
        else if (bus.mem_wdata != stall_dat) stall_bad++;
        stall_seen++;
        stall_left--;
        bus.mem_ready = 1'b0;
      end else begin
        bus.mem_ready = 1'b1;
      end
      if (bus.mem_we && bus.mem_ready) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
        wr_edge.push_back(cyc + 1);
      end
      if (bus.done) n_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mkvec(input logic [15:0] start, input logic [15:0] step);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = start + 16'(i) * step;
    return v;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
  endtask

  // Present a request at the current negedge; returns at the negedge after the capture edge
  // with in_valid still asserted.
  task automatic send(input logic [255:0] d, input logic [15:0] a, input logic [15:0] m,
                      output int cap);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_addr  = a;
    bus.in_mask  = m;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      cap = -1;
      return;
    end
    cap = cyc + 1;
    @(negedge clk);
  endtask

  // Wait (bounded) for done; returns at the negedge where done is high, e = edge preceding it.
  task automatic wait_done(input string tag, output int e);
    int t;
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    e = bus.done ? cyc : -1;
  endtask

  // Compare the write log with the lanes selected by mask, in ascending lane order.
  task automatic expect_drain(input string tag, input logic [255:0] d, input logic [15:0] base,
                              input logic [15:0] mask, input int cap);
    int j;
    logic [15:0] ea;
    logic [15:0] ed;
    j = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        ea = base + 16'(i);
        ed = d[16*i +: 16];
        check($sformatf("%s_addr%0d", tag, j),
              (j < wr_addr.size()) ? {16'h0, wr_addr[j]} : 32'hFFFF_FFFF, {16'h0, ea});
        check($sformatf("%s_data%0d", tag, j),
              (j < wr_data.size()) ? {16'h0, wr_data[j]} : 32'hFFFF_FFFF, {16'h0, ed});
        j++;
      end
    end
    check({tag, "_count"}, 32'(wr_addr.size()), 32'(j));
    if (wr_edge.size() > 0) check({tag, "_first_edge"}, 32'(wr_edge[0]), 32'(cap + 1));
  endtask

  initial begin
    logic [255:0] v;
    logic [255:0] v2;
    int cap;
    int cap2;
    int de;
    int nd0;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_addr  = '0;
    bus.in_mask  = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full mask, base 0x0100, lane i = 0x1000+i
    clear_log();
    v = mkvec(16'h1000, 16'h0001);
    send(v, 16'h0100, 16'hFFFF, cap);
    bus.in_valid = 1'b0;
    wait_done("full", de);
    expect_drain("full", v, 16'h0100, 16'hFFFF, cap);
    check("full_last_edge", (wr_edge.size() == 16) ? 32'(wr_edge[15]) : 32'hFFFF_FFFF, 32'(cap + 16));
    check("full_done_edge", 32'(de), 32'(cap + 16));
    @(negedge clk);
    check("full_ready_back", 32'(bus.in_ready), 32'd1);
    check("full_done_pulse", 32'(bus.done), 32'd0);

    // sparse mask 0x8421, base 0x0200
    clear_log();
    v = mkvec(16'h5000, 16'h0001);
    send(v, 16'h0200, 16'h8421, cap);
    bus.in_valid = 1'b0;
    wait_done("sparse", de);
    expect_drain("sparse", v, 16'h0200, 16'h8421, cap);
    check("sparse_addr2_hand", (wr_addr.size() > 2) ? {16'h0, wr_addr[2]} : 32'hFFFF_FFFF, 32'h020A);
    check("sparse_data3_hand", (wr_data.size() > 3) ? {16'h0, wr_data[3]} : 32'hFFFF_FFFF, 32'h500F);
    check("sparse_last_edge", (wr_edge.size() == 4) ? 32'(wr_edge[3]) : 32'hFFFF_FFFF, 32'(cap + 4));
    check("sparse_done_edge", 32'(de), 32'(cap + 4));
    @(negedge clk);

    // address wrap: base 0xFFFC
    clear_log();
    v = mkvec(16'hA000, 16'h0011);
    send(v, 16'hFFFC, 16'hFFFF, cap);
    bus.in_valid = 1'b0;
    wait_done("wrap", de);
    expect_drain("wrap", v, 16'hFFFC, 16'hFFFF, cap);
    check("wrap_addr3_hand", (wr_addr.size() > 3) ? {16'h0, wr_addr[3]} : 32'hFFFF_FFFF, 32'hFFFF);
    check("wrap_addr4_hand", (wr_addr.size() > 4) ? {16'h0, wr_addr[4]} : 32'hFFFF_FFFF, 32'h0000);
    check("wrap_addr15_hand", (wr_addr.size() > 15) ? {16'h0, wr_addr[15]} : 32'hFFFF_FFFF, 32'h000B);
    @(negedge clk);

    // mem_ready low for 3 cycles on lane 2
    clear_log();
    stall_addr = 16'h0302;
    stall_seen = 0;
    stall_bad  = 0;
    stall_left = 3;
    v = mkvec(16'h2000, 16'h0001);
    send(v, 16'h0300, 16'hFFFF, cap);
    bus.in_valid = 1'b0;
    wait_done("stall", de);
    expect_drain("stall", v, 16'h0300, 16'hFFFF, cap);
    check("stall_cycles", 32'(stall_seen), 32'd3);
    check("stall_held", 32'(stall_bad), 32'd0);
    check("stall_last_edge", (wr_edge.size() == 16) ? 32'(wr_edge[15]) : 32'hFFFF_FFFF, 32'(cap + 19));
    check("stall_done_edge", 32'(de), 32'(cap + 19));
    @(negedge clk);

    // mask 0, then a request presented during DONE
    clear_log();
    nd0 = n_done;
    v  = mkvec(16'h6000, 16'h0001);
    v2 = mkvec(16'h7000, 16'h0001);
    send(v, 16'h0700, 16'h0000, cap);
    check("zero_done_next", 32'(bus.done), 32'd1);
    check("zero_ready_low", 32'(bus.in_ready), 32'd0);
    send(v2, 16'h0400, 16'h0003, cap2);
    bus.in_valid = 1'b0;
    check("zero_second_cap", 32'(cap2), 32'(cap + 2));
    wait_done("second", de);
    check("second_done_edge", 32'(de), 32'(cap2 + 2));
    expect_drain("second", v2, 16'h0400, 16'h0003, cap2);
    @(negedge clk);
    check("zero_done_count", 32'(n_done - nd0), 32'd2);

    // reset after the 5th accepted write
    clear_log();
    nd0 = n_done;
    v = mkvec(16'h3000, 16'h0001);
    send(v, 16'h0500, 16'hFFFF, cap);
    bus.in_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (wr_addr.size() < 5 && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_writes", 32'(wr_addr.size()), 32'd5);
    check("mid_rst_addr4", (wr_addr.size() > 4) ? {16'h0, wr_addr[4]} : 32'hFFFF_FFFF, 32'h0504);
    check("mid_rst_no_done", 32'(n_done - nd0), 32'd0);

    clear_log();
    v = mkvec(16'h4000, 16'h0001);
    send(v, 16'h0600, 16'hFFFF, cap);
    bus.in_valid = 1'b0;
    wait_done("after_rst", de);
    expect_drain("after_rst", v, 16'h0600, 16'hFFFF, cap);
    check("after_rst_done_edge", 32'(de), 32'(cap + 16));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
